// File: rtl/dct_coeff_accum.sv
// One 2-D DCT coefficient for an 8x8 block: walks 64 positions through a cos LUT and pixel RAM,
// multiplies and accumulates, then rounds, shifts and saturates onto a valid/ready output.
module dct_coeff_accum #(
  parameter int PIX_W       = 8,
  parameter int COS_W       = 32,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_W       = 48,
  parameter int OUT_W       = 16,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic [2:0]              lut_n1,
  output logic [2:0]              lut_n2,
  input  logic signed [COS_W-1:0] cos_term,
  output logic                    pix_rd_en,
  output logic [5:0]              pix_rd_addr,
  input  logic [PIX_W-1:0]        pix_data,
  output logic signed [OUT_W-1:0] coeff,
  output logic                    coeff_valid,
  input  logic                    coeff_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [PIX_W:0] PIX_OFS =
    (PIX_W+1)'(LEVEL_SHIFT != 0 ? (1 << (PIX_W-1)) : 0);
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [5:0]               cnt_q;
  logic signed [COS_W-1:0]  cos_q;
  logic                     vld_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  coeff_q;

  logic signed [PIX_W:0]    pix_s;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  coeff_d;

  // Product stage: pix_data and cos_q both belong to the index issued last cycle.
  assign pix_s   = $signed({1'b0, pix_data} - PIX_OFS);
  assign prod    = ACC_W'(pix_s) * ACC_W'(cos_q);
  assign shifted = (acc_q + RND) >>> FRAC_BITS;

  always_comb begin
    if (shifted > SAT_MAX)      coeff_d = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) coeff_d = SAT_MIN[OUT_W-1:0];
    else                        coeff_d = shifted[OUT_W-1:0];
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 6'd63) state_d = DRAIN;
      // vld_q low means the 64th product has already landed in acc_q.
      DRAIN:   if (!vld_q) state_d = DONE;
      DONE:    if (coeff_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cos_q   <= '0;
      vld_q   <= 1'b0;
      acc_q   <= '0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= 1'b0;
      if (vld_q) acc_q <= acc_q + prod;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          cos_q <= cos_term;
          vld_q <= 1'b1;
          if (cnt_q != 6'd63) cnt_q <= cnt_q + 6'd1;
        end
        DRAIN: begin
          if (!vld_q) coeff_q <= coeff_d;
        end
        DONE: begin
          if (coeff_ready) cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign pix_rd_en   = (state_q == RUN);
  assign coeff_valid = (state_q == DONE);
  assign pix_rd_addr = cnt_q;
  assign lut_n1      = cnt_q[5:3];
  assign lut_n2      = cnt_q[2:0];
  assign coeff       = coeff_q;

endmodule
